// File: rtl/am2950_port.sv
`default_nettype none
// ============================================================================
// Module   : am2950_port
// Brief    : Bidirectional 8-bit I/O port in the style of the Am2950. R latches
//            the A bus and drives the B bus; S latches the B bus and drives the
//            A bus. Each register has a full flag and a sticky overrun flag.
// Revision : 1.0  initial release
// ============================================================================
module am2950_port #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   inout  wire  [WIDTH-1:0] a,
   inout  wire  [WIDTH-1:0] b,
   input  logic             ldr,
   input  logic             lds,
   input  logic             oeb_,
   input  logic             oea_,
   input  logic             clrr,
   input  logic             clrs,
   output logic             fr,
   output logic             fs,
   output logic             ovr,
   output logic             ovs
);

   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             fr_q, fr_d;
   logic             fs_q, fs_d;
   logic             ovr_q, ovr_d;
   logic             ovs_q, ovs_d;

   // Bus drivers are purely combinational so the register appears on its
   // output bus in the same cycle it is loaded; reset values follow the enables.
   assign b = oeb_ ? {WIDTH{1'bz}} : r_q;
   assign a = oea_ ? {WIDTH{1'bz}} : s_q;

   assign fr  = fr_q;
   assign fs  = fs_q;
   assign ovr = ovr_q;
   assign ovs = ovs_q;

   // Next-state for the R channel (A -> B). A load always wins over a clear;
   // overrun is set only by a load into an unacknowledged register with no
   // clear in the same edge, and a clear that coincides with a load leaves it.
   always_comb begin
      r_d   = r_q;
      fr_d  = fr_q;
      ovr_d = ovr_q;
      if (ldr) begin
         r_d  = a;
         fr_d = 1'b1;
         if (fr_q && !clrr) ovr_d = 1'b1;
      end else if (clrr) begin
         fr_d  = 1'b0;
         ovr_d = 1'b0;
      end
   end

   // Next-state for the S channel (B -> A), same rules as R, independent of it.
   always_comb begin
      s_d   = s_q;
      fs_d  = fs_q;
      ovs_d = ovs_q;
      if (lds) begin
         s_d  = b;
         fs_d = 1'b1;
         if (fs_q && !clrs) ovs_d = 1'b1;
      end else if (clrs) begin
         fs_d  = 1'b0;
         ovs_d = 1'b0;
      end
   end

   // State registers; reset overrides every load and clear request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q   <= '0;
         s_q   <= '0;
         fr_q  <= 1'b0;
         fs_q  <= 1'b0;
         ovr_q <= 1'b0;
         ovs_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         s_q   <= s_d;
         fr_q  <= fr_d;
         fs_q  <= fs_d;
         ovr_q <= ovr_d;
         ovs_q <= ovs_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_am2950_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_am2950_port
// Brief    : Self-checking bench for am2950_port. Expected values are queued
//            with each stimulus cycle and compared after the following edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_am2950_port;

   localparam int W = 8;
   localparam int SEL_A   = 0;
   localparam int SEL_B   = 1;
   localparam int SEL_FR  = 2;
   localparam int SEL_FS  = 3;
   localparam int SEL_OVR = 4;
   localparam int SEL_OVS = 5;

   typedef struct {
      string        tag;
      int           sel;
      logic [W-1:0] val;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, ldr, lds, oeb_, oea_, clrr, clrs;
   logic         fr, fs, ovr, ovs;
   logic         a_en, b_en;
   logic [W-1:0] a_drv, b_drv;
   wire  [W-1:0] a, b;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   assign a = a_en ? a_drv : {W{1'bz}};
   assign b = b_en ? b_drv : {W{1'bz}};

   am2950_port #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .ldr (ldr),
      .lds (lds),
      .oeb_(oeb_),
      .oea_(oea_),
      .clrr(clrr),
      .clrs(clrs),
      .fr  (fr),
      .fs  (fs),
      .ovr (ovr),
      .ovs (ovs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   function automatic logic [W-1:0] observe(input int sel);
      case (sel)
         SEL_A:   return a;
         SEL_B:   return b;
         SEL_FR:  return {{(W-1){1'b0}}, fr};
         SEL_FS:  return {{(W-1){1'b0}}, fs};
         SEL_OVR: return {{(W-1){1'b0}}, ovr};
         default: return {{(W-1){1'b0}}, ovs};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [W-1:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic push_r(input string tag, input logic [W-1:0] bv, input logic f, input logic o);
      push({tag, ".b"},   SEL_B,   bv);
      push({tag, ".fr"},  SEL_FR,  {7'd0, f});
      push({tag, ".ovr"}, SEL_OVR, {7'd0, o});
   endtask

   task automatic push_s(input string tag, input logic f, input logic o);
      push({tag, ".fs"},  SEL_FS,  {7'd0, f});
      push({tag, ".ovs"}, SEL_OVS, {7'd0, o});
   endtask

   // Advance one clock, then drain the scoreboard against the DUT outputs.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, observe(e.sel), e.val);
      end
      ldr  = 1'b0;
      lds  = 1'b0;
      clrr = 1'b0;
      clrs = 1'b0;
      rst  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ldr = 1'b0; lds = 1'b0; clrr = 1'b0; clrs = 1'b0;
      oeb_ = 1'b0; oea_ = 1'b0;
      a_en = 1'b0; b_en = 1'b0; a_drv = '0; b_drv = '0;

      // Reset with both drivers enabled: zeros on both buses, flags clear.
      push("rst.a", SEL_A, 8'h00);
      push_r("rst", 8'h00, 1'b0, 1'b0);
      push_s("rst", 1'b0, 1'b0);
      tick();

      // Simple A->B transfer then acknowledge.
      oea_ = 1'b1; a_en = 1'b1; a_drv = 8'b10101010; ldr = 1'b1;
      push_r("ld1", 8'b10101010, 1'b1, 1'b0);
      tick();
      clrr = 1'b1;
      push_r("clr1", 8'b10101010, 1'b0, 1'b0);
      tick();

      // Two loads without acknowledge -> overrun; clear drops both flags.
      a_drv = 8'b11110000; ldr = 1'b1;
      push_r("ovA", 8'b11110000, 1'b1, 1'b0);
      tick();
      a_drv = 8'b00001111; ldr = 1'b1;
      push_r("ovB", 8'b00001111, 1'b1, 1'b1);
      push_s("ovB", 1'b0, 1'b0);
      tick();
      clrr = 1'b1;
      push_r("ovclr", 8'b00001111, 1'b0, 1'b0);
      tick();

      // Overrun already set, then load+clear together: load wins, ovr kept.
      a_drv = 8'h11; ldr = 1'b1;
      push_r("lc1", 8'h11, 1'b1, 1'b0);
      tick();
      a_drv = 8'h22; ldr = 1'b1;
      push_r("lc2", 8'h22, 1'b1, 1'b1);
      tick();
      a_drv = 8'b01010101; ldr = 1'b1; clrr = 1'b1;
      push_r("lc3", 8'b01010101, 1'b1, 1'b1);
      tick();
      clrr = 1'b1;
      push_r("lc4", 8'b01010101, 1'b0, 1'b0);
      tick();

      // Full without overrun, load+clear together must not create an overrun.
      a_drv = 8'h33; ldr = 1'b1;
      push_r("lc5", 8'h33, 1'b1, 1'b0);
      tick();
      a_drv = 8'h44; ldr = 1'b1; clrr = 1'b1;
      push_r("lc6", 8'h44, 1'b1, 1'b0);
      tick();
      ldr = 1'b0;
      push_r("hold", 8'h44, 1'b1, 1'b0);
      tick();

      // B->A transfer, with R channel flags untouched.
      oeb_ = 1'b1; b_en = 1'b1; b_drv = 8'b11001100; lds = 1'b1;
      push_s("ls1", 1'b1, 1'b0);
      push("ls1.fr", SEL_FR, 8'h01);
      tick();
      b_en = 1'b0; a_en = 1'b0; oea_ = 1'b0;
      push("ls2.a", SEL_A, 8'b11001100);
      push_s("ls2", 1'b1, 1'b0);
      tick();
      // Drivers released: the bench's own value must appear unopposed.
      oea_ = 1'b1; a_en = 1'b1; a_drv = 8'b00110011;
      push("relA", SEL_A, 8'b00110011);
      tick();
      b_en = 1'b1; b_drv = 8'b10111011;
      push("relB", SEL_B, 8'b10111011);
      tick();
      // S overrun, independent of R.
      b_drv = 8'h77; lds = 1'b1;
      push_s("ovS", 1'b1, 1'b1);
      push("ovS.ovr", SEL_OVR, 8'h00);
      tick();

      // Both channels in one cycle, then reset clears everything.
      a_drv = 8'h5A; b_drv = 8'hA5; ldr = 1'b1; lds = 1'b1; clrs = 1'b1;
      push("dual.fr", SEL_FR, 8'h01);
      push_s("dual", 1'b1, 1'b1);
      tick();
      rst = 1'b1; ldr = 1'b1; lds = 1'b1;
      push("rst2.fr", SEL_FR, 8'h00);
      push("rst2.ovr", SEL_OVR, 8'h00);
      push_s("rst2", 1'b0, 1'b0);
      tick();
      a_en = 1'b0; b_en = 1'b0; oea_ = 1'b0; oeb_ = 1'b0;
      push("rst3.a", SEL_A, 8'h00);
      push("rst3.b", SEL_B, 8'h00);
      tick();

      // First load after reset: full, no overrun.
      oea_ = 1'b1; a_en = 1'b1; a_drv = 8'hC3; ldr = 1'b1;
      push_r("post", 8'hC3, 1'b1, 1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
